rom_uart_streamer: RTL
======================

Name: rom_uart_streamer

Overview:
Controller that sequences the ROM → UART transmit path.
- On a `go` pulse it walks ROM addresses from 0 to MSG_LEN-1.
- For each address it waits out the ROM read latency, latches the byte, hands it to uart_tx with a one-cycle start pulse, and waits for the transmitter to finish.
- It replaces the free-running ROM address fetcher and the ad-hoc ready→start glue with one handshake-correct FSM.

Parameters:
- ADDR_WIDTH, 5, ROM address width in bits.
- DATA_WIDTH, 8, ROM word / UART character width in bits.
- MSG_LEN, 2**ADDR_WIDTH, number of words sent per message; legal range 1..2**ADDR_WIDTH.
- ROM_LATENCY, 1, clock cycles from `addr` change to valid `rom_data`; legal range 1..7.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- go  in  1  start a message; sampled only in IDLE.
- loop  in  1  when 1 at end of message, restart at address 0 instead of returning to IDLE.
- abort  in  1  finish the byte in flight, then return to IDLE.
- addr  out  ADDR_WIDTH  ROM address.
- rom_data  in  DATA_WIDTH  ROM read data.
- tx_data  out  DATA_WIDTH  byte presented to uart_tx; registered.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_ready  in  1  uart_tx idle/ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a message completes or an abort takes effect.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, addr=0, tx_data=0, tx_start=0, busy=0, done=0, abort_pending=0, latency counter=0.
- FSM states: IDLE, FETCH, WAIT_RDY, START, WAIT_ACK, WAIT_DONE, NEXT.
- IDLE: addr held at 0. When go=1 → FETCH, with latency counter loaded to ROM_LATENCY.
- FETCH: decrement the counter each cycle; at 0 → WAIT_RDY. Total FETCH dwell is exactly ROM_LATENCY cycles after addr is stable.
- WAIT_RDY: when tx_ready=1, latch tx_data<=rom_data and go to START.
- START: tx_start=1 for exactly this cycle → WAIT_ACK.
- WAIT_ACK: wait for tx_ready=0 (transmitter accepted the byte) → WAIT_DONE. tx_start never re-asserts here, even if tx_ready stays high for extra cycles.
- WAIT_DONE: when tx_ready=1 → NEXT.
- NEXT, with last = (addr == MSG_LEN-1):
  - If abort_pending or (last and !loop): addr<=0, pulse done, → IDLE.
  - Else if last and loop: addr<=0, pulse done, → FETCH.
  - Else: addr<=addr+1 → FETCH.
- addr arithmetic is modulo 2**ADDR_WIDTH. With MSG_LEN=2**ADDR_WIDTH, the wrap from max to 0 happens only via the last rule above.
- abort: sampled in any non-IDLE state and sets abort_pending, which clears on entry to IDLE. A byte already in START/WAIT_ACK/WAIT_DONE is always completed; abort during FETCH/WAIT_RDY still exits at the next NEXT without transmitting? No: abort in FETCH/WAIT_RDY goes directly to IDLE with a done pulse and no tx_start.
- Simultaneous go and abort in IDLE: go ignored, stay IDLE.
- go while busy: ignored.
- Minimum per-byte overhead beyond the UART frame: ROM_LATENCY + 4 cycles.
- Reset mid-transmission: outputs return to reset values immediately; uart_tx may finish its frame, and the streamer ignores the resulting tx_ready edges while in IDLE.

Optional Feature:
ROM_UART_STREAMER_NUL_TERM_EN
- Defined: in WAIT_RDY, if rom_data == 0 the byte is not sent; behave as NEXT with end-of-message (done pulse; loop honoured). This allows C-string messages shorter than MSG_LEN.
- Undefined: zero bytes are transmitted like any other data; the message length is always MSG_LEN.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (3-bit, IDLE=0);
  - default DATA_WIDTH.
- No sub-module: the latency counter and address counter are small enough to stay inline. rom and uart_tx remain separate external instances.

Test Plan:
1. MSG_LEN=4, ROM = 48 69 21 0A, go pulse, loop=0, ROM_LATENCY=1 → exactly 4 tx_start pulses with tx_data 0x48, 0x69, 0x21, 0x0A in order; done pulses once; addr=0 and busy=0 afterwards.
2. Same setup with a uart_tx model holding tx_ready high 3 extra cycles after start → still one tx_start per byte, no duplicate bytes.
3. loop=1 for 2 messages, then loop=0 → 8 bytes 48 69 21 0A 48 69 21 0A, done pulses twice, then IDLE.
4. abort asserted during WAIT_DONE of byte 1 (0x69) → byte 0x69 completes, no third tx_start, done pulse, IDLE. abort in FETCH of byte 0 → zero tx_start, done pulse.
5. rst_n low during WAIT_DONE → addr=0, tx_start=0, busy=0 within the same cycle; after release, go restarts at 0x48.
6. NUL_TERM_EN defined, ROM = 41 42 00 43 → only 0x41, 0x42 sent, done pulse. Macro undefined → 41 42 00 43 all sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the ROM -> UART streamer: FSM state encoding and
// default character width.
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    // 3-bit state encoding, IDLE must stay 0 so a cleared register is idle.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_RDY  = 3'd2;
    localparam logic [2:0] S_START     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK  = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;
    localparam logic [2:0] S_NEXT      = 3'd6;

endpackage

// File: rtl/rom_uart_streamer.sv
// rom_uart_streamer: walks ROM addresses 0..MSG_LEN-1, waits out the ROM read
// latency, and hands each byte to uart_tx with a one-cycle start pulse,
// waiting for the transmitter to accept and finish each character.
// Optional build macro ROM_UART_STREAMER_NUL_TERM_EN: a zero byte ends the
// message early (C-string style) instead of being transmitted.
module rom_uart_streamer
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MSG_LEN     = 2**ADDR_WIDTH,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  loop,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MSG_LEN - 1);
    localparam logic [2:0]            LAT_INIT  = 3'(ROM_LATENCY);

    logic [2:0] state;
    logic [2:0] lat_cnt;
    logic       abort_pending;
    logic       abort_now;
    logic       last;

    // An abort seen this cycle acts immediately; one seen earlier is remembered.
    assign abort_now = abort | abort_pending;
    assign last      = (addr == LAST_ADDR);
    assign busy      = (state != S_IDLE);

    // Main sequencer: address walk, latency wait, start/ack handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr          <= '0;
            tx_data       <= '0;
            tx_start      <= 1'b0;
            done          <= 1'b0;
            abort_pending <= 1'b0;
            lat_cnt       <= '0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (state != S_IDLE && abort)
                abort_pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    addr          <= '0;
                    abort_pending <= 1'b0;
                    // go together with abort is treated as no request
                    if (go && !abort) begin
                        state   <= S_FETCH;
                        lat_cnt <= LAT_INIT;
                    end
                end

                // Dwell ROM_LATENCY cycles with addr stable so rom_data settles.
                S_FETCH: begin
                    if (abort_now) begin
                        addr          <= '0;
                        done          <= 1'b1;
                        abort_pending <= 1'b0;
                        state         <= S_IDLE;
                    end else if (lat_cnt <= 3'd1) begin
                        lat_cnt <= '0;
                        state   <= S_WAIT_RDY;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end

                S_WAIT_RDY: begin
                    if (abort_now) begin
                        addr          <= '0;
                        done          <= 1'b1;
                        abort_pending <= 1'b0;
                        state         <= S_IDLE;
                    end
`ifdef ROM_UART_STREAMER_NUL_TERM_EN
                    // NUL terminator: end of message without sending the byte
                    else if (rom_data == '0) begin
                        addr <= '0;
                        done <= 1'b1;
                        if (loop) begin
                            state   <= S_FETCH;
                            lat_cnt <= LAT_INIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
`endif
                    else if (tx_ready) begin
                        tx_data  <= rom_data;
                        tx_start <= 1'b1;
                        state    <= S_START;
                    end
                end

                // tx_start is high for exactly this one cycle
                S_START: state <= S_WAIT_ACK;

                // Ready dropping means the transmitter took the byte; a ready
                // that lingers high never produces a second start.
                S_WAIT_ACK: if (!tx_ready) state <= S_WAIT_DONE;

                S_WAIT_DONE: if (tx_ready) state <= S_NEXT;

                S_NEXT: begin
                    if (abort_now || (last && !loop)) begin
                        addr          <= '0;
                        done          <= 1'b1;
                        abort_pending <= 1'b0;
                        state         <= S_IDLE;
                    end else if (last) begin
                        addr    <= '0;
                        done    <= 1'b1;
                        state   <= S_FETCH;
                        lat_cnt <= LAT_INIT;
                    end else begin
                        addr    <= addr + ADDR_WIDTH'(1);
                        state   <= S_FETCH;
                        lat_cnt <= LAT_INIT;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
